// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the 16-bit MIPS program-counter unit and the decoder feeding it.
package pc_next_unit_pkg;

    // Datapath widths (word-addressed instruction memory)
    localparam int PC_W    = 16;
    localparam int IMM_W   = 6;
    localparam int JADDR_W = 12;
    localparam int RET_W   = 16;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    // Top-level run control: the core either executes or is parked until reset
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

    // Opcode constants used by the decoder that produces branch_eq/branch_ne/jump/halt_req
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_J     = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Widen a signed word offset to a full PC-width addend
    function automatic logic [PC_W-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
        return {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // True when two or more of the three control-flow decodes are asserted together
    function automatic logic multi_hot3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Decoder/ALU-side bundle for the PC unit: control-flow decodes in, PC and status out.
interface pc_next_unit_if;
    import pc_next_unit_pkg::*;

    logic               branch_eq;
    logic               branch_ne;
    logic               jump;
    logic [IMM_W-1:0]   imm;
    logic [JADDR_W-1:0] jaddr;
    logic               zero;
    logic               stall;
    logic               halt_req;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus1;
    logic               halted;
    logic [RET_W-1:0]   retired;
    logic               ctl_err;

    // Decoder/ALU side: drives the controls, observes PC and status
    modport master (
        output branch_eq, branch_ne, jump, imm, jaddr, zero, stall, halt_req,
        input  pc, pc_plus1, halted, retired, ctl_err
    );

    // PC unit side
    modport slave (
        input  branch_eq, branch_ne, jump, imm, jaddr, zero, stall, halt_req,
        output pc, pc_plus1, halted, retired, ctl_err
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational candidate next-PC values and branch resolution for the PC unit.
module pc_target_calc
    import pc_next_unit_pkg::*;
(
    input  logic [PC_W-1:0]    pc_i,
    input  logic               branch_eq_i,
    input  logic               branch_ne_i,
    input  logic               zero_i,
    input  logic [IMM_W-1:0]   imm_i,
    input  logic [JADDR_W-1:0] jaddr_i,
    output logic [PC_W-1:0]    pc_plus1_o,
    output logic [PC_W-1:0]    branch_target_o,
    output logic [PC_W-1:0]    jump_target_o,
    output logic               taken_o
);

    // Sequential, branch and jump targets; all additions wrap modulo 2^PC_W
    always_comb begin
        pc_plus1_o      = pc_i + {{(PC_W-1){1'b0}}, 1'b1};
        branch_target_o = pc_plus1_o + sign_extend_imm(imm_i);
        jump_target_o   = {pc_plus1_o[PC_W-1:JADDR_W], jaddr_i};
        taken_o         = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program counter register, RUN/HALT control, retire counter and sticky control-conflict flag.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_next_unit_if.slave bus
);

    pc_state_e          state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [RET_W-1:0]   retired_q;
    logic               ctl_err_q;
    logic               halted_q;

    logic [PC_W-1:0]    pc_plus1;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    jump_target;
    logic               taken;
    logic               retire;
    logic               multi_ctl;

    pc_target_calc u_target (
        .pc_i            (pc_q),
        .branch_eq_i     (bus.branch_eq),
        .branch_ne_i     (bus.branch_ne),
        .zero_i          (bus.zero),
        .imm_i           (bus.imm),
        .jaddr_i         (bus.jaddr),
        .pc_plus1_o      (pc_plus1),
        .branch_target_o (branch_target),
        .jump_target_o   (jump_target),
        .taken_o         (taken)
    );

    // An instruction retires only while running, not stalled, and not the halt instruction itself
    assign retire    = (state_q == ST_RUN) && !bus.stall && !bus.halt_req;
    assign multi_ctl = multi_hot3(bus.branch_eq, bus.branch_ne, bus.jump);

    // Next-PC select: jump beats a taken branch, which beats fall-through; hold when not retiring
    always_comb begin
        pc_d = pc_q;
        if (retire) begin
            if (bus.jump) begin
                pc_d = jump_target;
            end else if (taken) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc_plus1;
            end
        end
    end

    // RUN/HALT state machine together with the PC, retire count and error flag it governs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            halted_q  <= 1'b0;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            ctl_err_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                ST_RUN: begin
                    if (!bus.stall && bus.halt_req) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                    if (retire) begin
                        retired_q <= retired_q + {{(RET_W-1){1'b0}}, 1'b1};
                        if (multi_ctl) begin
                            ctl_err_q <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus1 = pc_plus1;
    assign bus.halted   = halted_q;
    assign bus.retired  = retired_q;
    assign bus.ctl_err  = ctl_err_q;

endmodule
